// File: rtl/fp_mul_issue_ctrl.sv
// Round-robin issue controller sharing one FP multiplier among N_REQ requesters.
// Owns the unit's operands, clock-enable and synchronous reset for each operation.
`timescale 1ns/1ps
module fp_mul_issue_ctrl #(
    parameter int N_REQ   = 2,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*32-1:0]      req_op_a_i,
    input  logic [N_REQ*32-1:0]      req_op_b_i,
    input  logic [N_REQ*TAG_W-1:0]   req_tag_i,
    output logic [31:0]              unit_op_a_o,
    output logic [31:0]              unit_op_b_o,
    output logic                     unit_clk_en_o,
    output logic                     unit_rst_n_o,
    input  logic                     unit_valid_i,
    input  logic [31:0]              unit_result_i,
    input  logic [2:0]               unit_flags_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [31:0]              rsp_result_o,
    output logic [3:0]               rsp_flags_o,
    output logic [TAG_W-1:0]         rsp_tag_o,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic                     busy_o
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [31:0]      CANON_NAN = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [31:0]      op_a_q, op_b_q;
    logic [TAG_W-1:0] tag_q;
    logic [ID_W-1:0]  id_q;
    logic [CNT_W-1:0] wd_cnt_q;
    logic [31:0]      rsp_result_q;
    logic [3:0]       rsp_flags_q;
    logic             unit_rst_n_q;
    logic             flush_by_wd_q;

    logic [31:0]      op_a_arr [N_REQ];
    logic [31:0]      op_b_arr [N_REQ];
    logic [TAG_W-1:0] tag_arr  [N_REQ];
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_fire;
    logic             wd_expired;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            op_a_arr[i] = req_op_a_i[i*32 +: 32];
            op_b_arr[i] = req_op_b_i[i*32 +: 32];
            tag_arr[i]  = req_tag_i[i*TAG_W +: TAG_W];
        end
    end

    // Scan from the farthest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[wrap_idx(rr_ptr_q, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    assign wd_expired = (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        if (flush_i) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_d    = ST_RUN;
                        grant_fire = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (unit_valid_i)    state_d = ST_RESP;
                    else if (wd_expired) state_d = ST_FLUSH;
                end
                ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
                ST_FLUSH: state_d = flush_by_wd_q ? ST_RESP : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Gated by the raw reset so no grant is visible while the controller is held in reset.
    always_comb begin
        req_ready_o = '0;
        if (grant_fire && rst_n_i) req_ready_o[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            tag_q         <= '0;
            id_q          <= '0;
            wd_cnt_q      <= '0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            unit_rst_n_q  <= 1'b0;
            flush_by_wd_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_rst_n_q <= (state_d != ST_FLUSH);

            if (grant_fire) begin
                op_a_q   <= op_a_arr[grant_idx];
                op_b_q   <= op_b_arr[grant_idx];
                tag_q    <= tag_arr[grant_idx];
                id_q     <= grant_idx;
                rr_ptr_q <= wrap_idx(grant_idx, 1);
            end

            if (state_q == ST_RUN && !flush_i) begin
                if (unit_valid_i) begin
                    rsp_result_q <= unit_result_i;
                    rsp_flags_q  <= {1'b0, unit_flags_i};
                    wd_cnt_q     <= '0;
                end else if (wd_expired) begin
                    rsp_result_q <= CANON_NAN;
                    rsp_flags_q  <= 4'b1000;
                    wd_cnt_q     <= '0;
                end else begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                end
            end else begin
                wd_cnt_q <= '0;
            end

            if (flush_i)
                flush_by_wd_q <= 1'b0;
            else if (state_q == ST_RUN && !unit_valid_i && wd_expired)
                flush_by_wd_q <= 1'b1;
        end
    end

    assign unit_op_a_o   = op_a_q;
    assign unit_op_b_o   = op_b_q;
    assign unit_clk_en_o = (state_q == ST_RUN);
    assign unit_rst_n_o  = unit_rst_n_q;
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_result_o  = rsp_result_q;
    assign rsp_flags_o   = rsp_flags_q;
    assign rsp_tag_o     = tag_q;
    assign rsp_id_o      = id_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Scoreboard bench for fp_mul_issue_ctrl with a behavioural multiplier stub on the unit side.
`timescale 1ns/1ps
module tb_fp_mul_issue_ctrl;
    localparam int N_REQ   = 2;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [3:0]       flags;
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic [0:0]       id;
    } rsp_t;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i;
    logic                   flush_i;
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic [N_REQ*32-1:0]    req_op_a_i;
    logic [N_REQ*32-1:0]    req_op_b_i;
    logic [N_REQ*TAG_W-1:0] req_tag_i;
    logic [31:0]            unit_op_a_o, unit_op_b_o;
    logic                   unit_clk_en_o, unit_rst_n_o;
    logic                   unit_valid_i;
    logic [31:0]            unit_result_i;
    logic [2:0]             unit_flags_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i = 1'b0;
    logic [31:0]            rsp_result_o;
    logic [3:0]             rsp_flags_o;
    logic [TAG_W-1:0]       rsp_tag_o;
    logic [0:0]             rsp_id_o;
    logic                   busy_o;

    int checks = 0;
    int errors = 0;
    rsp_t sb_q[$];
    int model_ptr = 0;
    logic [31:0]      cur_a [N_REQ];
    logic [31:0]      cur_b [N_REQ];
    logic [TAG_W-1:0] cur_tag [N_REQ];
    logic [31:0] run_a = '0, run_b = '0;
    logic stub_hang = 1'b0;
    int   stub_cnt = 0, stub_lat = 0;
    logic rdy_force = 1'b1, rdy_val = 1'b1;
    logic exp_rsp_next = 1'b0;

    fp_mul_issue_ctrl #(.N_REQ(N_REQ), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_tag_i(req_tag_i),
        .unit_op_a_o(unit_op_a_o), .unit_op_b_o(unit_op_b_o),
        .unit_clk_en_o(unit_clk_en_o), .unit_rst_n_o(unit_rst_n_o),
        .unit_valid_i(unit_valid_i), .unit_result_i(unit_result_i), .unit_flags_i(unit_flags_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
        .rsp_tag_o(rsp_tag_o), .rsp_id_o(rsp_id_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference single-precision multiply: specials by rule, normals through double arithmetic.
    function automatic logic [34:0] ref_fmul(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        real ra, rb;
        logic [63:0] d;
        logic [10:0] e11;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            return {3'b100, NAN};
        if (a_inf || b_inf)
            return {3'b000, a[31] ^ b[31], 8'hFF, 23'h0};
        if (a_zero || b_zero)
            return {3'b000, a[31] ^ b[31], 31'h0};
        ra  = $bitstoreal({a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'h0});
        rb  = $bitstoreal({b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'h0});
        d   = $realtobits(ra * rb);
        e11 = d[62:52] - 11'd896;
        return {3'b000, d[63], e11[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
    endfunction

    // Multiplier stub: synchronous reset, advances only when enabled, random latency.
    assign unit_valid_i = !stub_hang && (stub_cnt == stub_lat);
    assign {unit_flags_i, unit_result_i} = ref_fmul(unit_op_a_o, unit_op_b_o);

    always @(posedge clk_i) begin
        if (!unit_rst_n_o) begin
            stub_cnt <= 0;
        end else if (unit_clk_en_o) begin
            if (unit_valid_i) begin
                stub_cnt <= 0;
                stub_lat <= $urandom_range(0, 5);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    always @(posedge clk_i) begin
        #2;
        rsp_ready_i = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every handshake.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            exp_rsp_next = 1'b0;
        end else begin
            if (exp_rsp_next) checkOutput("rsp_latency", 64'(rsp_valid_o), 64'd1);
            exp_rsp_next = unit_clk_en_o && unit_valid_i && !flush_i;
            if (rsp_valid_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: actual result=%0h id=%0d required none",
                             rsp_result_o, rsp_id_o);
                end else begin
                    checkOutput("rsp_result", 64'(rsp_result_o), 64'(sb_q[0].result));
                    checkOutput("rsp_flags",  64'(rsp_flags_o),  64'(sb_q[0].flags));
                    checkOutput("rsp_tag",    64'(rsp_tag_o),    64'(sb_q[0].tag));
                    checkOutput("rsp_id",     64'(rsp_id_o),     64'(sb_q[0].id));
                    if (rsp_ready_i) void'(sb_q.pop_front());
                end
            end
            if (unit_clk_en_o) begin
                checkOutput("unit_op_a_hold", 64'(unit_op_a_o), 64'(run_a));
                checkOutput("unit_op_b_hold", 64'(unit_op_b_o), 64'(run_b));
            end
        end
    end

    task automatic driveReq();
        for (int i = 0; i < N_REQ; i++) begin
            req_op_a_i[i*32 +: 32]       = cur_a[i];
            req_op_b_i[i*32 +: 32]       = cur_b[i];
            req_tag_i[i*TAG_W +: TAG_W]  = cur_tag[i];
        end
    endtask

    task automatic newOperands(input int i);
        cur_a[i]   = rand_fp();
        cur_b[i]   = rand_fp();
        cur_tag[i] = TAG_W'($urandom);
    endtask

    // Waits for a grant, checks it against the round-robin model and queues the expected response.
    task automatic applyStimulus(input bit use_ovr, input logic [35:0] ovr, output int waited);
        int g;
        rsp_t e;
        logic [34:0] r;
        logic [N_REQ-1:0] exp_rdy;
        waited = 0;
        @(negedge clk_i);
        while (req_ready_o == '0 && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        if (req_ready_o == '0) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_wait: actual no grant in %0d cycles, required a grant", waited);
            return;
        end
        g = -1;
        for (int k = 0; k < N_REQ; k++)
            if (g < 0 && req_valid_i[(model_ptr + k) % N_REQ]) g = (model_ptr + k) % N_REQ;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checkOutput("req_ready_grant", 64'(req_ready_o), 64'(exp_rdy));
        if (g < 0) return;
        r = ref_fmul(cur_a[g], cur_b[g]);
        if (use_ovr)        {e.flags, e.result} = ovr;
        else if (stub_hang) {e.flags, e.result} = {4'b1000, NAN};
        else                {e.flags, e.result} = {1'b0, r};
        e.tag = cur_tag[g];
        e.id  = 1'(g);
        sb_q.push_back(e);
        run_a = cur_a[g];
        run_b = cur_b[g];
        model_ptr = (g + 1) % N_REQ;
        @(posedge clk_i);
        #1;
        newOperands(g);
        driveReq();
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk_i);
        while ((sb_q.size() != 0 || busy_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: actual %0d responses outstanding, required 0", sb_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: actual simulation still running, required finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int w, n;
        rst_n_i = 1'b0;
        flush_i = 1'b0;
        req_valid_i = '0;
        for (int i = 0; i < N_REQ; i++) newOperands(i);
        driveReq();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_busy",      64'(busy_o), 0);
        checkOutput("reset_unit_rst",  64'(unit_rst_n_o), 0);
        checkOutput("reset_clk_en",    64'(unit_clk_en_o), 0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid_o), 0);
        checkOutput("reset_req_ready", 64'(req_ready_o), 0);
        checkOutput("reset_op_a",      64'(unit_op_a_o), 0);
        checkOutput("reset_result",    64'(rsp_result_o), 0);
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        checkOutput("unit_rst_before_edge", 64'(unit_rst_n_o), 0);
        @(negedge clk_i);
        checkOutput("unit_rst_idle", 64'(unit_rst_n_o), 1);

        $display("[TB] single op 2.0 x 3.0");
        @(posedge clk_i); #1;
        cur_a[0] = 32'h4000_0000; cur_b[0] = 32'h4040_0000; cur_tag[0] = 4'd5;
        driveReq();
        req_valid_i = 2'b01;
        applyStimulus(1'b1, {4'b0000, 32'h40C0_0000}, w);
        req_valid_i = '0;
        waitIdle();

        $display("[TB] round-robin with both requesters valid");
        @(posedge clk_i); #1;
        rdy_force = 1'b0;
        req_valid_i = 2'b11;
        repeat (4) applyStimulus(1'b0, '0, w);
        req_valid_i = '0;
        waitIdle();

        $display("[TB] backpressure");
        @(posedge clk_i); #1;
        rdy_force = 1'b1; rdy_val = 1'b0;
        req_valid_i = 2'b01;
        applyStimulus(1'b0, '0, w);
        req_valid_i = 2'b10;
        n = 0;
        @(negedge clk_i);
        while (!rsp_valid_o && n < 50) begin @(negedge clk_i); n++; end
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_rsp_valid", 64'(rsp_valid_o), 1);
            checkOutput("bp_req_ready", 64'(req_ready_o), 0);
            checkOutput("bp_clk_en",    64'(unit_clk_en_o), 0);
            @(negedge clk_i);
        end
        @(posedge clk_i); #1 rdy_val = 1'b1;
        @(negedge clk_i);
        checkOutput("bp_handshake_valid", 64'(rsp_valid_o && rsp_ready_i), 1);
        applyStimulus(1'b0, '0, w);
        checkOutput("bp_next_grant_delay", 64'(w), 0);
        req_valid_i = '0;
        waitIdle();

        $display("[TB] exception passthrough inf x 0");
        @(posedge clk_i); #1;
        rdy_force = 1'b0;
        cur_a[0] = 32'h7F80_0000; cur_b[0] = 32'h0000_0000;
        driveReq();
        req_valid_i = 2'b01;
        applyStimulus(1'b1, {4'b0100, NAN}, w);
        req_valid_i = '0;
        waitIdle();

        $display("[TB] watchdog");
        @(posedge clk_i); #1;
        stub_hang = 1'b1;
        req_valid_i = 2'b10;
        applyStimulus(1'b1, {4'b1000, NAN}, w);
        req_valid_i = '0;
        n = 0;
        @(negedge clk_i);
        while (unit_clk_en_o && n < 100) begin n++; @(negedge clk_i); end
        checkOutput("wd_run_cycles",  64'(n), 64'(TIMEOUT));
        checkOutput("wd_flush_rst",   64'(unit_rst_n_o), 0);
        checkOutput("wd_flush_valid", 64'(rsp_valid_o), 0);
        @(negedge clk_i);
        checkOutput("wd_resp_rst",    64'(unit_rst_n_o), 1);
        checkOutput("wd_resp_valid",  64'(rsp_valid_o), 1);
        @(posedge clk_i); #1 stub_hang = 1'b0;
        waitIdle();

        $display("[TB] flush during RUN");
        @(posedge clk_i); #1;
        stub_hang = 1'b1;
        req_valid_i = 2'b01;
        applyStimulus(1'b0, '0, w);
        req_valid_i = '0;
        repeat (3) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        sb_q.delete();
        stub_hang = 1'b0;
        @(negedge clk_i);
        checkOutput("frun_unit_rst", 64'(unit_rst_n_o), 0);
        checkOutput("frun_clk_en",   64'(unit_clk_en_o), 0);
        @(negedge clk_i);
        checkOutput("frun_idle_busy", 64'(busy_o), 0);
        checkOutput("frun_idle_rst",  64'(unit_rst_n_o), 1);
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("frun_no_rsp", 64'(rsp_valid_o), 0);
        end

        $display("[TB] flush during RESP");
        @(posedge clk_i); #1;
        rdy_force = 1'b1; rdy_val = 1'b0;
        req_valid_i = 2'b11;
        applyStimulus(1'b0, '0, w);
        req_valid_i = '0;
        n = 0;
        @(negedge clk_i);
        while (!rsp_valid_o && n < 50) begin @(negedge clk_i); n++; end
        @(posedge clk_i); #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        sb_q.delete();
        @(negedge clk_i);
        checkOutput("fresp_unit_rst", 64'(unit_rst_n_o), 0);
        checkOutput("fresp_valid",    64'(rsp_valid_o), 0);
        @(negedge clk_i);
        checkOutput("fresp_idle_busy", 64'(busy_o), 0);

        $display("[TB] flush in IDLE with pending request, held two cycles");
        @(posedge clk_i); #1;
        rdy_force = 1'b0;
        req_valid_i = 2'b01;
        flush_i = 1'b1;
        @(negedge clk_i);
        checkOutput("fidle_no_grant", 64'(req_ready_o), 0);
        @(negedge clk_i);
        checkOutput("fidle_rst_1",    64'(unit_rst_n_o), 0);
        checkOutput("fidle_no_grant2", 64'(req_ready_o), 0);
        @(posedge clk_i); #1 flush_i = 1'b0;
        @(negedge clk_i);
        checkOutput("fidle_rst_ext",  64'(unit_rst_n_o), 0);
        applyStimulus(1'b0, '0, w);
        checkOutput("fidle_grant_delay", 64'(w), 0);
        req_valid_i = '0;
        waitIdle();

        $display("[TB] asynchronous reset during RUN");
        @(posedge clk_i); #1;
        stub_hang = 1'b1;
        req_valid_i = 2'b11;
        applyStimulus(1'b0, '0, w);
        repeat (2) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("areset_busy",      64'(busy_o), 0);
        checkOutput("areset_clk_en",    64'(unit_clk_en_o), 0);
        checkOutput("areset_unit_rst",  64'(unit_rst_n_o), 0);
        checkOutput("areset_req_ready", 64'(req_ready_o), 0);
        checkOutput("areset_op_a",      64'(unit_op_a_o), 0);
        checkOutput("areset_rsp_valid", 64'(rsp_valid_o), 0);
        sb_q.delete();
        model_ptr = 0;
        stub_hang = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        applyStimulus(1'b0, '0, w);
        req_valid_i = '0;
        waitIdle();

        $display("[TB] random traffic");
        for (int op = 0; op < 40; op++) begin
            @(posedge clk_i); #1;
            req_valid_i = N_REQ'($urandom_range(1, 3));
            applyStimulus(1'b0, '0, w);
        end
        req_valid_i = '0;
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
